// File: rtl/dvi_mode_ctrl.sv
// Frame-synchronous video-mode switcher: validates a new timing set, blanks on a
// frame boundary, restarts the timing generator on the new set, then unblanks.
module dvi_mode_ctrl #(
   parameter int H_W           = 12,
   parameter int V_W           = 11,
   parameter int BLANK_FRAMES  = 1,
   parameter int SETTLE_FRAMES = 2,
   parameter int RST_CYCLES    = 4,
   parameter int TIMEOUT       = 2000000,
   parameter int DEF_H_ACT     = 640,
   parameter int DEF_H_SS      = 656,
   parameter int DEF_H_SE      = 752,
   parameter int DEF_H_TOT     = 800,
   parameter int DEF_V_ACT     = 480,
   parameter int DEF_V_SS      = 490,
   parameter int DEF_V_SE      = 492,
   parameter int DEF_V_TOT     = 525
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [4*H_W-1:0] req_h_i,
   input  logic [4*V_W-1:0] req_v_i,
   input  logic             frame_end_i,
   output logic [4*H_W-1:0] h_cfg_o,
   output logic [4*V_W-1:0] v_cfg_o,
   output logic             timing_rst_o,
   output logic             blank_o,
   output logic             busy_o,
   output logic             req_err_o,
   output logic             timeout_o
);
   localparam int FMAX = (BLANK_FRAMES > SETTLE_FRAMES) ? BLANK_FRAMES : SETTLE_FRAMES;
   localparam int FC_W = $clog2(FMAX + 1);
   localparam int RC_W = $clog2(RST_CYCLES + 1);
   localparam int WD_W = $clog2(TIMEOUT + 1);

   localparam logic [4*H_W-1:0] DEF_H = {H_W'(DEF_H_TOT), H_W'(DEF_H_SE), H_W'(DEF_H_SS), H_W'(DEF_H_ACT)};
   localparam logic [4*V_W-1:0] DEF_V = {V_W'(DEF_V_TOT), V_W'(DEF_V_SE), V_W'(DEF_V_SS), V_W'(DEF_V_ACT)};

   typedef enum logic [2:0] {IDLE, CHECK, WAIT_EOF, BLANK, APPLY, SETTLE} state_e;

   state_e           state_q, state_d;
   logic [4*H_W-1:0] sh_h_q, sh_h_d, h_cfg_q, h_cfg_d;
   logic [4*V_W-1:0] sh_v_q, sh_v_d, v_cfg_q, v_cfg_d;
   logic [FC_W-1:0]  fcnt_q, fcnt_d;
   logic [RC_W-1:0]  rcnt_q, rcnt_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic             trst_q, trst_d, blank_q, blank_d, err_q, err_d, tmo_q, tmo_d;
   logic             fe_ok, wd_hit, watched, cfg_ok;

   function automatic logic order_ok(input int unsigned a, ss, se, tot);
      return (a != 0) && (a < ss) && (ss < se) && (se <= tot);
   endfunction

   always_comb begin
      state_d = state_q;
      sh_h_d  = sh_h_q;
      sh_v_d  = sh_v_q;
      h_cfg_d = h_cfg_q;
      v_cfg_d = v_cfg_q;
      fcnt_d  = fcnt_q;
      rcnt_d  = rcnt_q;
      trst_d  = trst_q;
      blank_d = blank_q;
      err_d   = 1'b0;
      tmo_d   = tmo_q;

      // Restart pulses can glitch the generator's frame_end, so they never count.
      fe_ok   = frame_end_i & ~trst_q;
      watched = (state_q == WAIT_EOF) || (state_q == BLANK) || (state_q == SETTLE);
      wd_hit  = watched && (wd_q == WD_W'(TIMEOUT - 1));
      cfg_ok  = order_ok(32'(sh_h_q[H_W-1:0]), 32'(sh_h_q[2*H_W-1:H_W]),
                         32'(sh_h_q[3*H_W-1:2*H_W]), 32'(sh_h_q[4*H_W-1:3*H_W])) &&
                order_ok(32'(sh_v_q[V_W-1:0]), 32'(sh_v_q[2*V_W-1:V_W]),
                         32'(sh_v_q[3*V_W-1:2*V_W]), 32'(sh_v_q[4*V_W-1:3*V_W]));

      case (state_q)
         IDLE: if (req_valid_i) begin
            sh_h_d  = req_h_i;
            sh_v_d  = req_v_i;
            tmo_d   = 1'b0;
            state_d = CHECK;
         end
         CHECK: if (cfg_ok) state_d = WAIT_EOF;
                else begin
                   err_d   = 1'b1;
                   state_d = IDLE;
                end
         WAIT_EOF: if (fe_ok || wd_hit) begin
            if (!fe_ok) tmo_d = 1'b1;
            fcnt_d  = '0;
            blank_d = 1'b1;
            state_d = BLANK;
         end
         BLANK: begin
            if ((fe_ok && fcnt_q == FC_W'(BLANK_FRAMES - 1)) || (!fe_ok && wd_hit)) begin
               if (!fe_ok) tmo_d = 1'b1;
               h_cfg_d = sh_h_q;
               v_cfg_d = sh_v_q;
               trst_d  = 1'b1;
               rcnt_d  = '0;
               state_d = APPLY;
            end else if (fe_ok) fcnt_d = fcnt_q + FC_W'(1);
         end
         APPLY: begin
            if (rcnt_q == RC_W'(RST_CYCLES - 1)) begin
               trst_d  = 1'b0;
               fcnt_d  = '0;
               state_d = SETTLE;
            end else rcnt_d = rcnt_q + RC_W'(1);
         end
         SETTLE: begin
            if ((fe_ok && fcnt_q == FC_W'(SETTLE_FRAMES - 1)) || (!fe_ok && wd_hit)) begin
               if (!fe_ok) tmo_d = 1'b1;
               blank_d = 1'b0;
               state_d = IDLE;
            end else if (fe_ok) fcnt_d = fcnt_q + FC_W'(1);
         end
         default: state_d = IDLE;
      endcase

      // Watchdog runs only while waiting on frames and restarts on any edge of progress.
      if (!watched || frame_end_i || state_d != state_q) wd_d = '0;
      else                                               wd_d = wd_q + WD_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         sh_h_q  <= '0;
         sh_v_q  <= '0;
         h_cfg_q <= DEF_H;
         v_cfg_q <= DEF_V;
         fcnt_q  <= '0;
         rcnt_q  <= '0;
         wd_q    <= '0;
         trst_q  <= 1'b0;
         blank_q <= 1'b0;
         err_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_h_q  <= sh_h_d;
         sh_v_q  <= sh_v_d;
         h_cfg_q <= h_cfg_d;
         v_cfg_q <= v_cfg_d;
         fcnt_q  <= fcnt_d;
         rcnt_q  <= rcnt_d;
         wd_q    <= wd_d;
         trst_q  <= trst_d;
         blank_q <= blank_d;
         err_q   <= err_d;
         tmo_q   <= tmo_d;
      end
   end

   assign req_ready_o  = (state_q == IDLE);
   assign busy_o       = (state_q != IDLE);
   assign h_cfg_o      = h_cfg_q;
   assign v_cfg_o      = v_cfg_q;
   assign timing_rst_o = trst_q;
   assign blank_o      = blank_q;
   assign req_err_o    = err_q;
   assign timeout_o    = tmo_q;
endmodule

// File: tb/tb_dvi_mode_ctrl.sv
// Scoreboard bench for dvi_mode_ctrl: stimulus predicts each mode change, a
// negedge monitor measures what the DUT did and compares on completion.
module tb_dvi_mode_ctrl;
   localparam int H_W = 12, V_W = 11, BF = 1, SF = 2, RC = 4, TO = 100;
   localparam logic [47:0] DH = {12'd800, 12'd752, 12'd656, 12'd640};
   localparam logic [43:0] DV = {11'd525, 11'd492, 11'd490, 11'd480};

   logic clk_i = 0, rst_ni = 0;
   logic req_valid_i = 0, req_ready_o;
   logic [4*H_W-1:0] req_h_i = '0, h_cfg_o;
   logic [4*V_W-1:0] req_v_i = '0, v_cfg_o;
   logic frame_end_i, timing_rst_o, blank_o, busy_o, req_err_o, timeout_o;
   logic fe_gen = 0, fe_force = 0, fe_en = 1;

   assign frame_end_i = fe_gen | fe_force;
   always #5 clk_i = ~clk_i;

   dvi_mode_ctrl #(.H_W(H_W), .V_W(V_W), .BLANK_FRAMES(BF), .SETTLE_FRAMES(SF),
                   .RST_CYCLES(RC), .TIMEOUT(TO)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_h_i(req_h_i), .req_v_i(req_v_i), .frame_end_i(frame_end_i),
      .h_cfg_o(h_cfg_o), .v_cfg_o(v_cfg_o), .timing_rst_o(timing_rst_o), .blank_o(blank_o),
      .busy_o(busy_o), .req_err_o(req_err_o), .timeout_o(timeout_o));

   typedef struct {
      bit err; logic [47:0] h; logic [43:0] v; bit to;
      int lat; int rl; int pre; int post; bit blk;
   } exp_t;

   exp_t q[$];
   exp_t me;
   logic [47:0] cur_h = DH;
   logic [43:0] cur_v = DV;
   int tests = 0, fails = 0;
   int cyc = 0, done_cyc = 0, xfer_cyc = 0;
   bit act = 0, blk = 0;
   int lat, rl, pre, post;

   function automatic void chk(input string nm, input longint a, input longint e);
      tests++;
      if (a != e) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, a, e);
      end
   endfunction

   function automatic bit legal(input int f[4]);
      return f[0] > 0 && f[0] < f[1] && f[1] < f[2] && f[2] <= f[3];
   endfunction

   // Frame pulses every 21..61 clocks, always inside the watchdog window.
   initial forever begin
      repeat ($urandom_range(60, 20)) @(posedge clk_i);
      #1 fe_gen = fe_en;
      @(posedge clk_i);
      #1 fe_gen = 0;
   end

   always @(negedge clk_i) begin
      if (!rst_ni) act = 0;
      else begin
         cyc++;
         if (timing_rst_o) chk("rst_needs_blank", blank_o, 1);
         if (!busy_o && blank_o) chk("blank_when_idle", blank_o, 0);
         if (act) begin
            lat++;
            if (timing_rst_o) rl++;
            if (blank_o) blk = 1;
            if (frame_end_i && blank_o && !timing_rst_o) begin
               if (rl == 0) pre++; else post++;
            end
            if (!busy_o) begin
               act = 0;
               done_cyc = cyc;
               if (q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL unexpected_completion: got 1 expected 0");
               end else begin
                  me = q.pop_front();
                  chk("req_err", req_err_o, me.err);
                  chk("h_cfg", h_cfg_o, me.h);
                  chk("v_cfg", v_cfg_o, me.v);
                  chk("timeout", timeout_o, me.to);
                  if (me.lat >= 0) chk("latency", lat, me.lat);
                  chk("rst_len", rl, me.rl);
                  chk("blank_frames", pre, me.pre);
                  chk("settle_frames", post, me.post);
                  chk("blank_seen", blk, me.blk);
               end
            end
         end
         if (req_valid_i && req_ready_o) begin
            act = 1; lat = 0; rl = 0; pre = 0; post = 0; blk = 0;
            xfer_cyc = cyc;
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the transfer edge.
   task automatic send(input int hf[4], input int vf[4], input bit tmo, input bit keep);
      exp_t e;
      bit ok;
      int n = 0;
      req_h_i = {12'(hf[3]), 12'(hf[2]), 12'(hf[1]), 12'(hf[0])};
      req_v_i = {11'(vf[3]), 11'(vf[2]), 11'(vf[1]), 11'(vf[0])};
      req_valid_i = 1;
      @(negedge clk_i);
      while (!req_ready_o && n < 5000) begin
         @(negedge clk_i);
         n++;
      end
      if (!req_ready_o) begin
         tests++; fails++;
         $display("FAIL accept_wait: got 0 expected 1");
      end else begin
         ok = legal(hf) && legal(vf);
         e.err = !ok;
         e.h = ok ? req_h_i : cur_h;
         e.v = ok ? req_v_i : cur_v;
         if (ok) begin cur_h = req_h_i; cur_v = req_v_i; end
         e.to = ok && tmo;
         e.lat = !ok ? 2 : (tmo ? 3 * TO + RC + 2 : -1);
         e.rl = ok ? RC : 0;
         e.pre = (ok && !tmo) ? BF : 0;
         e.post = (ok && !tmo) ? SF : 0;
         e.blk = ok;
         q.push_back(e);
      end
      @(posedge clk_i);
      #1;
      if (!keep) req_valid_i = 0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (q.size() != 0 && n < 20000) begin
         @(negedge clk_i);
         n++;
      end
      if (q.size() != 0) begin
         tests++; fails++;
         $display("FAIL completion_wait: got %0d pending expected 0", q.size());
         q.delete();
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk_defaults(input string tag);
      chk({tag, "_h"}, h_cfg_o, DH);
      chk({tag, "_v"}, v_cfg_o, DV);
      chk({tag, "_ready"}, req_ready_o, 1);
      chk({tag, "_blank"}, blank_o, 0);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_trst"}, timing_rst_o, 0);
      chk({tag, "_err"}, req_err_o, 0);
      chk({tag, "_tmo"}, timeout_o, 0);
   endtask

   initial begin
      #200_000;
      $display("FAIL global_time_limit: got expired expected finish");
      $fatal(1, "time limit");
   end

   initial begin
      int hf[4], vf[4], n;
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1;
      @(negedge clk_i);
      chk_defaults("reset");
      @(posedge clk_i); #1;

      // 800x600, then reject, then field-order boundaries
      send('{800, 840, 968, 1056}, '{600, 601, 605, 628}, 0, 0);
      chk("ready_drop", req_ready_o, 0);
      wait_done();
      send('{640, 600, 700, 800}, '{480, 490, 492, 525}, 0, 0);
      wait_done();
      send('{640, 656, 752, 752}, '{480, 490, 492, 492}, 0, 0);
      wait_done();
      send('{640, 656, 752, 800}, '{0, 490, 492, 525}, 0, 0);
      wait_done();
      send('{640, 640, 752, 800}, '{480, 490, 492, 525}, 0, 0);
      wait_done();
      send('{640, 656, 656, 800}, '{480, 490, 492, 525}, 0, 0);
      wait_done();
      send('{640, 656, 752, 800}, '{480, 490, 526, 525}, 0, 0);
      wait_done();

      // Frame pulses stop: every stage has to be pushed by the watchdog
      fe_en = 0;
      repeat (3) @(posedge clk_i);
      #1;
      send('{1024, 1048, 1184, 1344}, '{768, 771, 777, 806}, 1, 0);
      wait_done();
      fe_en = 1;
      send('{800, 840, 968, 1056}, '{600, 601, 605, 628}, 0, 0);
      chk("timeout_clear", timeout_o, 0);
      wait_done();

      // Held request plus a frame pulse landing inside the restart pulse
      send('{640, 656, 752, 800}, '{480, 490, 492, 525}, 0, 1);
      fork
         begin
            n = 0;
            @(negedge clk_i);
            while (!timing_rst_o && n < 5000) begin @(negedge clk_i); n++; end
            @(posedge clk_i); #1 fe_force = 1;
            @(posedge clk_i); #1 fe_force = 0;
         end
         send('{720, 736, 798, 858}, '{480, 489, 495, 525}, 0, 0);
      join
      chk("b2b_first_idle", xfer_cyc - done_cyc, 0);
      wait_done();

      for (int i = 0; i < 12; i++) begin
         if ($urandom_range(2, 0) != 0) begin
            hf[0] = $urandom_range(1000, 1);  hf[1] = hf[0] + $urandom_range(100, 1);
            hf[2] = hf[1] + $urandom_range(100, 1); hf[3] = hf[2] + $urandom_range(100, 0);
         end else for (int k = 0; k < 4; k++) hf[k] = $urandom_range(4095, 0);
         vf[0] = $urandom_range(1000, 1);  vf[1] = vf[0] + $urandom_range(100, 1);
         vf[2] = vf[1] + $urandom_range(100, 1); vf[3] = vf[2] + $urandom_range(100, 0);
         if ($urandom_range(4, 0) == 0) vf[2] = vf[3] + 1;
         send(hf, vf, 0, 0);
         wait_done();
      end

      // Reset while blanking: the pending mode must be lost
      send('{800, 840, 968, 1056}, '{600, 601, 605, 628}, 0, 0);
      n = 0;
      @(negedge clk_i);
      while (!blank_o && n < 5000) begin @(negedge clk_i); n++; end
      chk("reached_blank", blank_o, 1);
      @(posedge clk_i);
      #1 rst_ni = 0;
      q.delete();
      cur_h = DH;
      cur_v = DV;
      #1 chk_defaults("midreset");
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1;
      send('{1024, 1048, 1184, 1344}, '{768, 771, 777, 806}, 0, 0);
      wait_done();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/dvi_mode_ctrl.md
Name: dvi_mode_ctrl

Overview:
Frame-synchronous video-mode controller in the pixel clock domain, placed between a host/config source and the DVI timing generator. It accepts a new timing set over a valid/ready handshake and validates it. It then waits for a frame boundary, blanks the datapath, applies the new timing with a timing-generator restart, and releases blanking after the new timing has settled. A watchdog forces the change if frame boundaries stop arriving.

Parameters:
H_W, 12, width of horizontal timing fields
V_W, 11, width of vertical timing fields
BLANK_FRAMES, 1, frames blanked on old timing before apply (>=1)
SETTLE_FRAMES, 2, frames blanked on new timing after apply (>=1)
RST_CYCLES, 4, timing_rst_o pulse length in clocks (>=1)
TIMEOUT, 2000000, clocks without frame_end_i before forced advance
DEF_H_ACT/DEF_H_SS/DEF_H_SE/DEF_H_TOT, 640/656/752/800, reset horizontal timing
DEF_V_ACT/DEF_V_SS/DEF_V_SE/DEF_V_TOT, 480/490/492/525, reset vertical timing

Ports:
clk_i  in  1  pixel clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  new mode request valid
req_ready_o  out  1  controller can accept request
req_h_i  in  4*H_W  {total, sync_end, sync_start, active}, horizontal
req_v_i  in  4*V_W  {total, sync_end, sync_start, active}, vertical
frame_end_i  in  1  1-clk pulse from timing generator, last pixel of frame
h_cfg_o  out  4*H_W  applied horizontal timing, same packing
v_cfg_o  out  4*V_W  applied vertical timing, same packing
timing_rst_o  out  1  synchronous restart to timing generator
blank_o  out  1  forces DE low and black on the encoders
busy_o  out  1  mode change in progress
req_err_o  out  1  1-clk pulse: request rejected
timeout_o  out  1  sticky: a watchdog advance occurred; cleared by next accepted request

Behaviour:
- Reset (async assert, sync release): state IDLE; h_cfg_o/v_cfg_o = DEF_*; blank_o=0; timing_rst_o=0; busy_o=0; req_err_o=0; timeout_o=0; req_ready_o=1.
- Handshake: transfer on req_valid_i & req_ready_o. req_ready_o=1 only in IDLE. Request fields are captured into a shadow register on transfer. Inputs are ignored outside IDLE.
- States:
  - IDLE: transfer -> CHECK.
  - CHECK (1 clk): the field is valid iff 0 < active < sync_start < sync_end <= total, for both H and V. Invalid -> req_err_o=1 this cycle, -> IDLE; outputs unchanged. Valid -> WAIT_EOF.
  - WAIT_EOF: on frame_end_i -> BLANK, with frame counter = 0.
  - BLANK: blank_o=1. Count frame_end_i; at the BLANK_FRAMES-th pulse -> APPLY.
  - APPLY: on the first cycle, h_cfg_o/v_cfg_o <= shadow. timing_rst_o=1 for exactly RST_CYCLES clks, blank_o=1, then -> SETTLE with counter = 0.
  - SETTLE: blank_o=1. Count frame_end_i; at the SETTLE_FRAMES-th pulse -> IDLE. blank_o falls the clock after that pulse.
- busy_o=1 in every state except IDLE; this includes CHECK.
- frame_end_i is ignored in IDLE, CHECK and APPLY; pulses coinciding with timing_rst_o are not counted.
- Watchdog: a counter is cleared on each state entry and on every frame_end_i. In WAIT_EOF, BLANK and SETTLE, reaching TIMEOUT advances as if the awaited final pulse arrived and sets timeout_o. WAIT_EOF advances to BLANK; BLANK advances to APPLY; SETTLE advances to IDLE.
- Counter widths: frame counters are sized to $clog2(max+1); the watchdog counter is sized to $clog2(TIMEOUT+1). No wrap is possible.
- Reset mid-operation: everything returns to reset values, including the DEF_* timing. Any pending request is lost.
- Back-to-back requests: a new request is accepted in the first IDLE cycle after SETTLE. No queueing.

Test Plan:
- Reset, no stimulus -> h_cfg_o={800,752,656,640}, v_cfg_o={525,492,490,480}, ready=1, blank/busy/rst=0.
- Valid 800x600 request (H 800/840/968/1056, V 600/601/605/628), frame_end every 1000 clks -> ready=0 next clk. blank_o rises 1 clk after the first frame_end and stays high through 1 frame. cfg updates, timing_rst_o high 4 clks, blank_o low 1 clk after the 2nd post-apply frame_end.
- Invalid request (H sync_start=600 < active=640) -> req_err_o pulse exactly 2 clks after transfer, cfg unchanged, back in IDLE; blank_o never asserted.
- frame_end_i held low after request (TIMEOUT=100) -> forced advance after each 100-clk wait, timeout_o=1, cfg applied, busy_o=0 after 300+RST_CYCLES+2 clks; timeout_o clears on next accepted request.
- rst_ni low during BLANK -> immediately blank_o=0, busy_o=0, cfg=DEF_*, ready=1; request never applied.
- req_valid_i held high during change, frame_end coinciding with timing_rst_o -> second request accepted only after IDLE; the coinciding pulse is not counted, so SETTLE needs 2 further pulses.
